// File: rtl/fifo_sync.sv
// Single-clock FIFO over an inferred two-port RAM: wrapping pointers, occupancy count,
// registered full/empty/almost flags, and sticky overflow/underflow bits.
module fifo_sync #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int AF_LEVEL = 252,
  parameter int AE_LEVEL = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_l,
  input  logic                         i_wr_dv,
  input  logic [WIDTH-1:0]             i_wr_data,
  output logic                         o_full,
  output logic                         o_af_flag,
  input  logic                         i_rd_en,
  output logic                         o_rd_dv,
  output logic [WIDTH-1:0]             o_rd_data,
  output logic                         o_empty,
  output logic                         o_ae_flag,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             ae_q, ae_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_dv_q, rd_dv_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_ok, rd_ok;

  always_comb begin
    wr_ok     = i_wr_dv & ~full_q;
    rd_ok     = i_rd_en & ~empty_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    rd_dv_d   = rd_ok;

    // Explicit wrap compare keeps non-power-of-two depths correct.
    if (wr_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    if (rd_ok) begin
      rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags follow the next count so they move on the same edge as o_count.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    ovf_d   = ovf_q | (i_wr_dv & full_q);
    udf_d   = udf_q | (i_rd_en & empty_q);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_l) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_dv_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      rd_dv_q   <= rd_dv_d;
      rd_data_q <= rd_data_d;
    end
  end

  // RAM is not reset; a write in a reset cycle must still be blocked.
  always_ff @(posedge i_clk) begin
    if (i_rst_l && wr_ok) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_af_flag   = af_q;
  assign o_ae_flag   = ae_q;
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;
  assign o_rd_dv     = rd_dv_q;
  assign o_rd_data   = rd_data_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync (DEPTH=4, AF=3, AE=1): vector table for flags/count,
// queue-model scoreboard for read data ordering.
module tb_fifo_sync;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_l;
  logic             wr_dv;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             full, af, rd_dv, empty, ae, ovf, udf;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    count;

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .i_clk(clk), .i_rst_l(rst_l), .i_wr_dv(wr_dv), .i_wr_data(wr_data),
    .o_full(full), .o_af_flag(af), .i_rd_en(rd_en), .o_rd_dv(rd_dv),
    .o_rd_data(rd_data), .o_empty(empty), .o_ae_flag(ae), .o_count(count),
    .o_overflow(ovf), .o_underflow(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;   // 1 = assert reset this cycle
    logic       wr;
    logic [7:0] data;
    logic       rd;
    int         cnt;
    logic       f, e, a_f, a_e, ov, un, dv;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] model_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] last_rd;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rst, input logic wr, input logic [7:0] d,
                             input logic rd, input int cnt, input logic f, input logic e,
                             input logic a_f, input logic a_e, input logic ov,
                             input logic un, input logic dv);
    vec_t r;
    r.rst = rst; r.wr = wr; r.data = d; r.rd = rd; r.cnt = cnt;
    r.f = f; r.e = e; r.a_f = a_f; r.a_e = a_e; r.ov = ov; r.un = un; r.dv = dv;
    return r;
  endfunction

  // Drive one cycle, update the queue model from its own pre-edge state,
  // then check every output one delta after the edge.
  task automatic apply(input vec_t t, input int idx);
    @(negedge clk);
    rst_l   = ~t.rst;
    wr_dv   = t.wr;
    wr_data = t.data;
    rd_en   = t.rd;
    if (t.rst) begin
      model_q.delete();
      exp_rd_q.delete();
      last_rd = '0;
    end else begin
      logic wr_acc, rd_acc;
      wr_acc = t.wr && (model_q.size() < DEPTH);
      rd_acc = t.rd && (model_q.size() > 0);
      if (rd_acc) exp_rd_q.push_back(model_q.pop_front());
      if (wr_acc) model_q.push_back(t.data);
    end
    @(posedge clk);
    #1;
    chk($sformatf("v%0d count", idx), int'(count), t.cnt);
    chk($sformatf("v%0d model_count", idx), int'(count), model_q.size());
    chk($sformatf("v%0d full", idx), int'(full), int'(t.f));
    chk($sformatf("v%0d empty", idx), int'(empty), int'(t.e));
    chk($sformatf("v%0d af", idx), int'(af), int'(t.a_f));
    chk($sformatf("v%0d ae", idx), int'(ae), int'(t.a_e));
    chk($sformatf("v%0d overflow", idx), int'(ovf), int'(t.ov));
    chk($sformatf("v%0d underflow", idx), int'(udf), int'(t.un));
    chk($sformatf("v%0d rd_dv", idx), int'(rd_dv), int'(t.dv));
    if (rd_dv) begin
      if (exp_rd_q.size() == 0) begin
        chk($sformatf("v%0d unexpected_rd", idx), 1, 0);
      end else begin
        last_rd = exp_rd_q.pop_front();
        chk($sformatf("v%0d rd_data", idx), int'(rd_data), int'(last_rd));
      end
    end else begin
      chk($sformatf("v%0d rd_hold", idx), int'(rd_data), int'(last_rd));
    end
  endtask

  initial begin
    rst_l = 1'b0; wr_dv = 1'b0; wr_data = '0; rd_en = 1'b0;
    last_rd = '0;

    //         rst wr data  rd cnt f  e  af ae ov un dv
    vecs.push_back(v(0, 1, 8'h01, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h02, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h03, 0, 3, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h04, 0, 4, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h55, 0, 4, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 3, 0, 0, 1, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 2, 0, 0, 0, 0, 1, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 0, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 1, 0));
    vecs.push_back(v(0, 1, 8'h09, 1, 1, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 1, 1));
    vecs.push_back(v(0, 1, 8'h0A, 0, 1, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(v(0, 1, 8'h0B, 0, 2, 0, 0, 0, 0, 1, 1, 0));
    for (int k = 0; k < 6; k++)
      vecs.push_back(v(0, 1, 8'h0C + 8'(k), 1, 2, 0, 0, 0, 0, 1, 1, 1));
    vecs.push_back(v(0, 1, 8'h20, 0, 3, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(v(1, 1, 8'h77, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 1, 8'h21, 0, 1, 0, 0, 0, 1, 0, 1, 0));
    vecs.push_back(v(0, 1, 8'h22, 0, 2, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 8'h23, 0, 3, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 8'h24, 0, 4, 1, 0, 1, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 8'h25, 1, 3, 0, 0, 1, 0, 1, 1, 1));
    vecs.push_back(v(0, 0, 8'h00, 1, 2, 0, 0, 0, 0, 1, 1, 1));

    // Reset held for 4 clocks with requests active; none may leak through.
    wr_dv = 1'b1; wr_data = 8'hEE; rd_en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_l = 1'b1; wr_dv = 1'b0; rd_en = 1'b0;
    #1;
    chk("rst empty", int'(empty), 1);
    chk("rst ae", int'(ae), 1);
    chk("rst full", int'(full), 0);
    chk("rst af", int'(af), 0);
    chk("rst count", int'(count), 0);
    chk("rst rd_dv", int'(rd_dv), 0);
    chk("rst rd_data", int'(rd_data), 0);
    chk("rst overflow", int'(ovf), 0);
    chk("rst underflow", int'(udf), 0);

    foreach (vecs[i]) apply(vecs[i], i);

    // Idle cycles: output data must hold and no stray pulse may appear.
    for (int k = 0; k < 2; k++)
      apply(v(0, 0, 8'h00, 0, 2, 0, 0, 0, 0, 1, 1, 0), 100 + k);

    chk("scoreboard drained", exp_rd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
